uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
- Serial receiver for the CPU's UART output line (idle high, 1 start bit low, 8 data bits LSB first, 1 stop bit high). Each bit lasts CLKS_PER_BIT system clocks.
- Turns the line back into bytes and presents them through a valid/ready holding register.
- Used in loopback rigs and on a second board to capture CPU output. It replaces bench-only deserialisation with synthesizable RTL.

Parameters:
- WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 2, system clocks per bit period. Legal range is 2 or more.
- SYNC_STAGES, 2, flip-flop synchronizer depth on rx_line. Legal range is 2 or more.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_line  in  1  serial input, idle high, asynchronous to clk.
- rx_data  out  WIDTH  received byte held in the holding register.
- rx_valid  out  1  holding register contains an unread byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE; synchronizer flops preset to 1.
- rx_s is the synchronizer output. rx_line reaches rx_s after SYNC_STAGES clocks.
- HALF = CLKS_PER_BIT/2 (integer divide). A baud counter counts clocks inside the current state; a bit index counts 0..WIDTH-1.
- IDLE:
  - rx_s=0 -> START, counter=0.
- START:
  - When counter reaches HALF-1, sample rx_s.
  - Sample 0 -> DATA, counter=0, index=0.
  - Sample 1 -> glitch; return to IDLE with no outputs.
- DATA:
  - Every CLKS_PER_BIT clocks, sample rx_s into shift[index], LSB first. This places each sample near mid-bit.
  - After index WIDTH-1 is sampled -> STOP.
- STOP:
  - Sample rx_s after CLKS_PER_BIT clocks.
  - Sample 1 -> byte complete; return to IDLE.
  - Sample 0 -> frame_err pulses for 1 cycle, byte discarded -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s=1, then -> IDLE. A low line is never taken as a new start bit from this state.
- Byte complete, evaluated in the cycle after the stop sample:
  - rx_valid=0 -> load rx_data, rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle -> load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0 -> keep the old byte, drop the new one, pulse overrun.
- Handshake:
  - rx_valid and rx_valid&rx_ready -> rx_valid=0 next cycle unless a new byte loads in that same cycle.
  - rx_data is stable while rx_valid=1.
- Back-to-back frames: a start edge in the first IDLE cycle after STOP is accepted. No idle gap is required.
- Latency: rx_valid rises SYNC_STAGES+1 clocks after the middle of the stop bit, ±1 clock of sampling phase.
- Reset mid-frame: the partial byte is lost; a held byte is cleared. After release the receiver waits in IDLE for the next falling edge. It may mis-frame if reset is released mid-frame; this is acceptable and documented.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, STOP, WAIT_IDLE;
  - line constants: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- Sub-module: sync_bit, a SYNC_STAGES-deep synchronizer with async reset preset to 1. It is reusable for other async inputs.

Test Plan:
1. CLKS_PER_BIT=2, rx_ready=1; send 0xA5 -> rx_valid pulses once with rx_data=0xA5; frame_err=0, overrun=0.
2. rx_line driven by the CPU running the add program -> bytes 1,2,3,…,254 captured in order, no errors.
3. Stop bit forced low on 0x3C -> frame_err pulses once, rx_valid stays 0. Line held low 10 bit times -> no new byte; after the line goes high, 0x55 is received correctly.
4. rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun pulses once. Raise rx_ready -> 0x11 accepted, rx_valid=0.
5. Glitch: rx_line low for 1 clock with CLKS_PER_BIT=8 -> returns to IDLE, no outputs. Next, assert rst_n=0 in the middle of 0xF0 -> all outputs 0 immediately; a subsequent clean 0x0F is received.
6. rx_valid=1 with rx_ready asserted exactly in the byte-complete cycle of the next frame -> old byte consumed, new byte loaded, rx_valid stays 1, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART byte receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous input; resets to the idle-high level.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the async input through STAGES flops; preset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// UART receiver: 1 start, WIDTH data bits LSB first, 1 stop; bytes leave via a valid/ready holding register.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_line,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             rx_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic             ferr_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_line),
    .q     (rx_s)
  );

  // Frame FSM state, baud counter, bit index and deserialiser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: start is checked at half a bit, later bits one full bit apart (near mid-bit).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s == START_BIT) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A high sample here means the falling edge was a glitch.
          state_d = (rx_s == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          // Right-shift in at the MSB so the first (LSB) bit ends at bit 0.
          shift_d = {rx_s, shift_q[WIDTH-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WIDTH - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s == STOP_BIT) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A broken frame may leave the line low; only a return to idle re-arms start detection.
        cnt_d = '0;
        if (rx_s == LINE_IDLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: completed bytes load when empty or when the old byte leaves this same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      done_q    <= done_d;
      overrun   <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: one instance at 2 clocks/bit, one at 8 clocks/bit.
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line2 = 1'b1, line8 = 1'b1;
  logic       rdy2 = 1'b1, rdy8 = 1'b0;
  logic [7:0] d2, d8;
  logic       v2, v8, fe2, fe8, ov2, ov8, bz2, bz8;

  int vectors = 0;
  int miscompares = 0;
  int hs2 = 0, hs8 = 0, fec2 = 0, fec8 = 0, ovc2 = 0, ovc8 = 0;
  logic [7:0] q2[$], q8[$];
  logic [7:0] e2, e8, pd2, pd8;
  logic       ph2 = 1'b0, ph8 = 1'b0;
  int         base_hs, base_fe, base_ov;

  always #5 clk = ~clk;

  uart_byte_rx #(.WIDTH(8), .CLKS_PER_BIT(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_line(line2), .rx_data(d2), .rx_valid(v2),
    .rx_ready(rdy2), .frame_err(fe2), .overrun(ov2), .busy(bz2));

  uart_byte_rx #(.WIDTH(8), .CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .rx_line(line8), .rx_data(d8), .rx_valid(v8),
    .rx_ready(rdy8), .frame_err(fe8), .overrun(ov8), .busy(bz8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 2) line2 = v;
    else        line8 = v;
  endtask

  task automatic bit_wait(input int w);
    repeat (w) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int w, input logic [7:0] b, input bit stop_ok);
    set_line(w, 1'b0);
    bit_wait(w);
    for (int i = 0; i < 8; i++) begin
      set_line(w, b[i]);
      bit_wait(w);
    end
    set_line(w, stop_ok);
    bit_wait(w);
    set_line(w, 1'b1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard side: pop an expected byte on every handshake, count pulses, check data stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      ph2 = 1'b0;
      ph8 = 1'b0;
    end else begin
      if (v2 && rdy2) begin
        hs2++;
        if (q2.size() == 0) chk("spurious_byte2", {24'd0, d2}, 32'hFFFF_FFFF);
        else begin e2 = q2.pop_front(); chk("data2", {24'd0, d2}, {24'd0, e2}); end
      end
      if (v8 && rdy8) begin
        hs8++;
        if (q8.size() == 0) chk("spurious_byte8", {24'd0, d8}, 32'hFFFF_FFFF);
        else begin e8 = q8.pop_front(); chk("data8", {24'd0, d8}, {24'd0, e8}); end
      end
      if (ph2 && v2) chk("stable2", {24'd0, d2}, {24'd0, pd2});
      if (ph8 && v8) chk("stable8", {24'd0, d8}, {24'd0, pd8});
      if (fe2) fec2++;
      if (fe8) fec8++;
      if (ov2) ovc2++;
      if (ov8) ovc8++;
      ph2 = v2 && !rdy2; pd2 = d2;
      ph8 = v8 && !rdy8; pd8 = d8;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    cycles(3);
    chk("rst_valid2", {31'd0, v2}, 0);
    chk("rst_data2", {24'd0, d2}, 0);
    chk("rst_busy2", {31'd0, bz2}, 0);
    chk("rst_ferr2", {31'd0, fe2}, 0);
    chk("rst_ovr2", {31'd0, ov2}, 0);
    chk("rst_valid8", {31'd0, v8}, 0);
    chk("rst_busy8", {31'd0, bz8}, 0);
    rst_n = 1'b1;
    cycles(4);

    // 1: single byte, consumer ready
    q2.push_back(8'hA5);
    frame(2, 8'hA5, 1'b1);
    cycles(8);
    chk("t1_handshakes", hs2, 1);
    chk("t1_ferr", fec2, 0);
    chk("t1_ovr", ovc2, 0);
    chk("t1_pending", q2.size(), 0);

    // 2: 1..254 back-to-back, no idle gap
    for (int i = 1; i <= 254; i++) begin
      q2.push_back(8'(i));
      frame(2, 8'(i), 1'b1);
    end
    cycles(8);
    chk("t2_handshakes", hs2, 255);
    chk("t2_pending", q2.size(), 0);
    chk("t2_errs", fec2 + ovc2, 0);

    // 3: stop bit low, line held low 10 bits, then a clean byte
    frame(2, 8'h3C, 1'b0);
    line2 = 1'b0;
    cycles(20);
    chk("t3_ferr", fec2, 1);
    chk("t3_busy_wait", {31'd0, bz2}, 1);
    chk("t3_valid", {31'd0, v2}, 0);
    line2 = 1'b1;
    cycles(6);
    chk("t3_idle", {31'd0, bz2}, 0);
    q2.push_back(8'h55);
    frame(2, 8'h55, 1'b1);
    cycles(8);
    chk("t3_handshakes", hs2, 256);
    chk("t3_ferr_after", fec2, 1);

    // 4: consumer stalled, second byte overruns
    rdy2 = 1'b0;
    q2.push_back(8'h11);
    frame(2, 8'h11, 1'b1);
    frame(2, 8'h22, 1'b1);
    cycles(6);
    chk("t4_ovr", ovc2, 1);
    chk("t4_valid", {31'd0, v2}, 1);
    chk("t4_data", {24'd0, d2}, 32'h11);
    rdy2 = 1'b1;
    cycles(2);
    chk("t4_drained", {31'd0, v2}, 0);
    chk("t4_pending", q2.size(), 0);

    // 6: ready arrives exactly in the byte-complete cycle of the next frame
    rdy2 = 1'b0;
    q2.push_back(8'h66);
    frame(2, 8'h66, 1'b1);
    cycles(4);
    chk("t6_held", {31'd0, v2}, 1);
    base_ov = ovc2;
    q2.push_back(8'h77);
    frame(2, 8'h77, 1'b1);
    repeat (2) @(posedge clk);
    #1 rdy2 = 1'b1;
    chk("t6_valid_pre", {31'd0, v2}, 1);
    @(posedge clk);
    #1 rdy2 = 1'b0;
    chk("t6_valid_post", {31'd0, v2}, 1);
    chk("t6_data_new", {24'd0, d2}, 32'h77);
    cycles(4);
    chk("t6_ovr", ovc2, base_ov);
    chk("t6_still_valid", {31'd0, v2}, 1);
    rdy2 = 1'b1;
    cycles(3);
    chk("t6_pending", q2.size(), 0);

    // 5a: one-clock glitch at 8 clocks/bit
    line8 = 1'b0;
    @(posedge clk);
    #1 line8 = 1'b1;
    cycles(3);
    chk("t5_glitch_busy", {31'd0, bz8}, 1);
    cycles(6);
    chk("t5_glitch_idle", {31'd0, bz8}, 0);
    chk("t5_glitch_out", hs8 + fec8 + ovc8 + {31'd0, v8}, 0);

    // 5b: held byte plus reset in the middle of a frame
    rdy8 = 1'b0;
    frame(8, 8'h3A, 1'b1);
    cycles(6);
    chk("t5_held_valid", {31'd0, v8}, 1);
    chk("t5_held_data", {24'd0, d8}, 32'h3A);
    fork
      frame(8, 8'hF0, 1'b1);
      begin
        cycles(30);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, v8}, 0);
        chk("t5_rst_data", {24'd0, d8}, 0);
        chk("t5_rst_busy", {31'd0, bz8}, 0);
        chk("t5_rst_ferr", {31'd0, fe8}, 0);
        chk("t5_rst_ovr", {31'd0, ov8}, 0);
      end
    join
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    base_hs = hs8;
    base_fe = fec8;
    rdy8 = 1'b1;
    q8.push_back(8'h0F);
    frame(8, 8'h0F, 1'b1);
    cycles(16);
    chk("t5_clean_hs", hs8, base_hs + 1);
    chk("t5_clean_pending", q8.size(), 0);
    chk("t5_clean_ferr", fec8, base_fe);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
